// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack operation sequencer: default sizes,
// opcode encodings and the sequencer state enumeration.
package stack_seq_pkg;

  localparam int WORD_DEF     = 8;
  localparam int LENGTH_DEF   = 64;
  localparam int POINTERL_DEF = 6;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_PEEK = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;

  typedef enum logic [3:0] {
    IDLE,
    PUSH,
    POP1,
    CAP1,
    POP2,
    CAP2,
    PUSHR,
    TOS,
    RESP
  } state_t;

endpackage

// File: rtl/stack_op_sequencer.sv
// Sequences stack commands (PUSH/POP/PEEK/DUP/ADD/SUB) onto an external
// single-port stack through one-cycle strobes and returns one response
// per command through a valid/ready handshake.
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int WORD     = WORD_DEF,
  parameter int LENGTH   = LENGTH_DEF,
  parameter int POINTERL = POINTERL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [WORD-1:0]     cmd_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WORD-1:0]     res_data,
  output logic                res_err,
  output logic                st_push,
  output logic                st_pop,
  output logic                st_tos,
  output logic [WORD-1:0]     st_d_in,
  input  logic [WORD-1:0]     st_d_out,
  output logic [POINTERL-1:0] depth
);

  // One entry is kept in reserve: pushes stop at LENGTH-1 entries.
  localparam logic [POINTERL-1:0] FULL = POINTERL'(LENGTH - 1);
  localparam logic [POINTERL-1:0] ONE  = POINTERL'(1);
  localparam logic [POINTERL-1:0] TWO  = POINTERL'(2);

  state_t          state, next_state;
  logic [2:0]      op_q;
  logic [WORD-1:0] data_q;
  logic [WORD-1:0] a_q;
  logic [WORD-1:0] b_q;
  logic [WORD-1:0] result;
  logic            cmd_legal;
  logic            accept;

  function automatic logic legal(input logic [2:0] op, input logic [POINTERL-1:0] d);
    case (op)
      OP_PUSH:         legal = (d < FULL);
      OP_POP, OP_PEEK: legal = (d >= ONE);
      OP_DUP:          legal = (d >= ONE) && (d < FULL);
      OP_ADD, OP_SUB:  legal = (d >= TWO);
      default:         legal = 1'b0;
    endcase
  endfunction

  // A is the former top of stack, B the entry beneath it; DUP re-pushes A.
  function automatic logic [WORD-1:0] alu(input logic [2:0] op,
                                          input logic [WORD-1:0] a,
                                          input logic [WORD-1:0] b);
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = b - a;
      default: alu = a;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign cmd_legal = legal(cmd_op, depth);
  assign result    = alu(op_q, a_q, b_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state selection and per-state stack strobes.
  always_comb begin
    next_state = state;
    st_push    = 1'b0;
    st_pop     = 1'b0;
    st_tos     = 1'b0;
    st_d_in    = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (!cmd_legal) next_state = RESP;
          else begin
            case (cmd_op)
              OP_PUSH:                next_state = PUSH;
              OP_PEEK, OP_DUP:        next_state = TOS;
              default:                next_state = POP1;
            endcase
          end
        end
      end
      PUSH: begin
        st_push    = 1'b1;
        st_d_in    = data_q;
        next_state = RESP;
      end
      POP1: begin
        st_pop     = 1'b1;
        next_state = CAP1;
      end
      TOS: begin
        st_tos     = 1'b1;
        next_state = CAP1;
      end
      CAP1: begin
        case (op_q)
          OP_POP, OP_PEEK: next_state = RESP;
          OP_DUP:          next_state = PUSHR;
          default:         next_state = POP2;
        endcase
      end
      POP2: begin
        st_pop     = 1'b1;
        next_state = CAP2;
      end
      CAP2: next_state = PUSHR;
      PUSHR: begin
        st_push    = 1'b1;
        st_d_in    = result;
        next_state = RESP;
      end
      RESP: if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command latch, operand capture, depth tracking and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      data_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      depth     <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_data  <= '0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        if (!cmd_legal) begin
          res_valid <= 1'b1;
          res_err   <= 1'b1;
          res_data  <= '0;
        end
      end
      case (state)
        PUSH: begin
          depth     <= depth + ONE;
          res_valid <= 1'b1;
          res_err   <= 1'b0;
          res_data  <= data_q;
        end
        POP1, POP2: depth <= depth - ONE;
        CAP1: begin
          a_q <= st_d_out;
          if (op_q == OP_POP || op_q == OP_PEEK) begin
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_data  <= st_d_out;
          end
        end
        CAP2: b_q <= st_d_out;
        PUSHR: begin
          depth     <= depth + ONE;
          res_valid <= 1'b1;
          res_err   <= 1'b0;
          res_data  <= result;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
